psum_norm: RTL and testbench
============================

// Module: psum_norm
// PURPOSE
//  Normalisation stage directly downstream of the core's psum output and of the inter-core sum FIFO.
//  Per input vector it does four things:
//   - accepts one vector of col signed psums;
//   - forms the local sum of |psum| and pushes it to the peer core's sync FIFO;
//   - pops the peer's sum from the local sync FIFO;
//   - divides each element by the global total, producing col signed bw-bit normalised outputs.
//  Single clock domain. The clk0/clk1 crossing stays inside the sync FIFOs.
// PARAMETERS
//  col      8            elements per psum vector
//  bw       8            output element width (signed)
//  bw_psum  2*bw+4 (20)  input psum element width (signed)
//  bw_sum   bw_psum+4    width of local/remote/total sum (unsigned); matches sync FIFO width
// PORTS
//  clk        in   1             single clock
//  reset      in   1             asynchronous, active-low reset
//  psum_in    in   col*bw_psum   psum vector; element k at [k*bw_psum +: bw_psum]
//  psum_valid in   1             psum_in valid; accepted when psum_valid & ready
//  ready      out  1             block idle, can accept a vector
//  sum_out    out  bw_sum        local |psum| sum, to peer sync FIFO write data
//  sum_wr     out  1             one-cycle write strobe for sum_out
//  sum_full   in   1             peer sync FIFO full
//  rsum_in    in   bw_sum        remote sum, sync FIFO head (valid whenever !rsum_empty)
//  rsum_empty in   1             sync FIFO empty
//  rsum_rd    out  1             sync FIFO pop; data captured in the same cycle
//  norm_out   out  col*bw        normalised vector; element k at [k*bw +: bw]
//  out_valid  out  1             one-cycle pulse; norm_out holds its value until the next pulse
// BEHAVIOUR
//  Reset (reset==0, async) values:
//   - state=IDLE, ready=1;
//   - sum_wr, rsum_rd, out_valid = 0;
//   - sum_out, norm_out, internal registers = 0.
//   Reset mid-operation aborts with no further FIFO push or pop.
//  FSM states: IDLE -> SUM -> WAIT -> DIV -> DONE -> IDLE
//   IDLE: ready=1. On psum_valid: latch psum_in, ready<=0, go to SUM.
//   SUM:
//    - local = sum over k of |psum[k]|, unsigned, bw_sum bits, no overflow (col*2^(bw_psum-1) < 2^bw_sum).
//    - |most-negative| = 2^(bw_psum-1), exact.
//    - If !sum_full: sum_out<=local, sum_wr=1 for exactly one cycle, go to WAIT.
//    - Else stay in SUM with sum_wr=0.
//   WAIT:
//    - rsum_rd = !rsum_empty (combinational).
//    - On a pop: total = local + rsum_in (bw_sum bits; the 2*2^22 max fits), go to DIV with idx=0.
//   DIV: elements are processed serially, idx 0..col-1, via the seq_divider sub-module.
//    - q = (|psum[idx]| << (bw-1)) / total, unsigned restoring division.
//    - Each element takes exactly DIV_CYC = bw_psum+bw cycles (1 load + iterations, padded).
//    - Magnitude saturates at 2^(bw-1)-1 = 127 (q=128 occurs only when |psum| == total).
//    - Result = sign(psum) ? -mag : mag; psum==0 gives 0.
//    - total==0: every element gives 0, same cycle count, no divider fault.
//   DONE: norm_out updated, out_valid=1 for one cycle, go to IDLE (ready=1 the following cycle).
//  Latency (no backpressure, remote sum present), accept at cycle T:
//   - sum_wr at T+1, rsum_rd at T+2;
//   - out_valid at T+3+col*DIV_CYC, which is T+227 at defaults.
//  Ordering and stalls:
//   - Exactly one push and one pop per vector.
//   - The pop always follows the push, so two cores cannot deadlock.
//   - psum_valid while !ready is ignored; the producer holds the vector until accepted.
// STRUCTURE
//  Shared package (norm_pkg):
//   - bw, bw_psum, bw_sum, DIV_CYC constants;
//   - state enum {IDLE,SUM,WAIT,DIV,DONE};
//   - abs/saturate functions.
//  Sub-module seq_divider:
//   - ports clk/reset, start, dividend[bw_psum+bw-2:0], divisor[bw_sum-1:0], quot, done;
//   - fixed latency DIV_CYC.
// TESTING
//  1 Uniform: all psum=100, rsum=800 -> sum_out=800 (sum_wr at T+1), total=1600, all norm_out=8 at T+227.
//  2 Sign: psum={-400,400,0,0,0,0,0,0}, rsum=0 -> total=800, out={-64,64,0,0,0,0,0,0}.
//  3 Saturate: psum[0]=500, others 0, rsum=0 -> out[0]=127 (not 128), others 0.
//  4 Zero: all psum=0, rsum=0 -> sum_out=0, all out 0, out_valid still at T+227.
//  5 Backpressure:
//     - sum_full=1 for 10 cycles -> sum_wr delayed exactly 10;
//     - then rsum_empty=1 for 20 cycles -> no rsum_rd; out_valid shifted by 30.
//  6 Reset mid-DIV:
//     - drop reset at cycle T+100 -> all outputs 0, ready=1, no extra sum_wr or rsum_rd;
//     - the next vector completes normally.

Source files
------------

// File: rtl/psum_norm_pkg.sv
// Shared constants, FSM state type and small arithmetic helpers for the
// psum normalisation stage.
package psum_norm_pkg;

  localparam int unsigned col     = 8;              // elements per psum vector
  localparam int unsigned bw      = 8;              // normalised element width (signed)
  localparam int unsigned bw_psum = 2 * bw + 4;     // psum element width (signed)
  localparam int unsigned bw_sum  = bw_psum + 4;    // local/remote/total sum width (unsigned)
  localparam int unsigned DVD_W   = bw_psum + bw - 1; // dividend width: |psum| << (bw-1)
  localparam int unsigned DIV_CYC = bw_psum + bw;   // cycles per element: 1 load + DVD_W steps

  typedef enum logic [2:0] {
    StIdle,
    StSum,
    StWait,
    StDiv,
    StDone
  } state_e;

  // Magnitude of a signed psum; the most-negative value maps to 2^(bw_psum-1) exactly.
  function automatic logic [bw_psum-1:0] abs_psum(input logic [bw_psum-1:0] v);
    return v[bw_psum-1] ? -v : v;
  endfunction

  // Clamp an unsigned quotient to the largest positive bw-bit magnitude.
  function automatic logic [bw-2:0] sat_mag(input logic [DVD_W-1:0] q);
    return (|q[DVD_W-1:bw-1]) ? '1 : q[bw-2:0];
  endfunction

endpackage

// File: rtl/psum_norm_seq_divider.sv
// Serial unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   start       load dividend/divisor (one cycle)
//   dividend    unsigned numerator, DVD_W bits
//   divisor     unsigned denominator, bw_sum bits (zero gives all-ones, no fault)
//   quot        quotient, valid in the cycle done is high
//   done        high in the last cycle, DIV_CYC-1 cycles after start
module seq_divider
  import psum_norm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DVD_W-1:0]  dividend,
  input  logic [bw_sum-1:0] divisor,
  output logic [DVD_W-1:0]  quot,
  output logic              done
);

  localparam int unsigned CntW = $clog2(DVD_W);

  logic              run_q;
  logic [CntW-1:0]   cnt_q;
  logic [bw_sum-1:0] rem_q, dvs_q;
  logic [DVD_W-1:0]  q_q;

  logic [bw_sum:0]   rem_sh, diff;
  logic              fits;
  logic [bw_sum-1:0] rem_n;
  logic [DVD_W-1:0]  q_n;

  // One restoring step; the quotient register shifts dividend bits out as
  // quotient bits shift in.
  always_comb begin
    rem_sh = {rem_q, q_q[DVD_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    fits   = !diff[bw_sum];
    rem_n  = fits ? diff[bw_sum-1:0] : rem_sh[bw_sum-1:0];
    q_n    = {q_q[DVD_W-2:0], fits};
  end

  // The final step's result is presented combinationally so the element
  // finishes in exactly DIV_CYC cycles including the load cycle.
  assign done = run_q && (cnt_q == CntW'(DVD_W - 1));
  assign quot = q_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      q_q   <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= divisor;
      q_q   <= dividend;
    end else if (run_q) begin
      rem_q <= rem_n;
      q_q   <= q_n;
      cnt_q <= cnt_q + CntW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/psum_norm.sv
// Normalises one psum vector by the global |psum| total shared with a peer core.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   psum_in, psum_valid    signed psum vector and its valid (taken when ready)
//   ready                  idle, can accept a vector
//   sum_out, sum_wr        local |psum| sum and its one-cycle push strobe to the peer FIFO
//   sum_full               peer FIFO full
//   rsum_in, rsum_empty    remote sum at local FIFO head, FIFO empty
//   rsum_rd                local FIFO pop, data taken in the same cycle
//   norm_out, out_valid    normalised vector (held) and its one-cycle valid pulse
module psum_norm
  import psum_norm_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] psum_in,
  input  logic                   psum_valid,
  output logic                   ready,
  output logic [bw_sum-1:0]      sum_out,
  output logic                   sum_wr,
  input  logic                   sum_full,
  input  logic [bw_sum-1:0]      rsum_in,
  input  logic                   rsum_empty,
  output logic                   rsum_rd,
  output logic [col*bw-1:0]      norm_out,
  output logic                   out_valid
);

  localparam int unsigned IdxW = $clog2(col);

  state_e                 state_q, state_d;
  logic [col*bw_psum-1:0] psum_q, psum_d;
  logic [bw_sum-1:0]      sum_q, sum_d, total_q, total_d, local_in;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   run_q, run_d;
  logic [col*bw-1:0]      res_q, res_d, norm_q, norm_d;

  logic [bw_psum-1:0]     cur_psum;
  logic [bw-2:0]          mag;
  logic [bw-1:0]          mag_ext, elem;
  logic                   div_start, div_done;
  logic [DVD_W-1:0]       div_quot;

  // Local sum is formed from the incoming vector at accept time so that
  // sum_out is already valid in the first SUM cycle alongside sum_wr.
  always_comb begin
    local_in = '0;
    for (int k = 0; k < int'(col); k++) begin
      local_in = local_in + bw_sum'(abs_psum(psum_in[k*bw_psum +: bw_psum]));
    end
  end

  assign cur_psum = psum_q[idx_q*bw_psum +: bw_psum];
  assign mag      = sat_mag(div_quot);
  assign mag_ext  = {1'b0, mag};
  // A zero total forces every element to zero regardless of the divider output.
  assign elem     = (total_q == '0) ? '0 : (cur_psum[bw_psum-1] ? -mag_ext : mag_ext);

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend ({abs_psum(cur_psum), {(bw - 1){1'b0}}}),
    .divisor  (total_q),
    .quot     (div_quot),
    .done     (div_done)
  );

  always_comb begin
    state_d   = state_q;
    psum_d    = psum_q;
    sum_d     = sum_q;
    total_d   = total_q;
    idx_d     = idx_q;
    run_d     = run_q;
    res_d     = res_q;
    norm_d    = norm_q;
    ready     = 1'b0;
    sum_wr    = 1'b0;
    rsum_rd   = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (psum_valid) begin
          psum_d  = psum_in;
          sum_d   = local_in;
          state_d = StSum;
        end
      end
      StSum: begin
        if (!sum_full) begin
          sum_wr  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        rsum_rd = !rsum_empty;
        if (!rsum_empty) begin
          total_d = sum_q + rsum_in;
          idx_d   = '0;
          run_d   = 1'b0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        div_start = !run_q;
        if (div_start) run_d = 1'b1;
        if (div_done) begin
          run_d = 1'b0;
          res_d[idx_q*bw +: bw] = elem;
          if (idx_q == IdxW'(col - 1)) begin
            norm_d  = res_d;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      psum_q  <= '0;
      sum_q   <= '0;
      total_q <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      res_q   <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      res_q   <= res_d;
      norm_q  <= norm_d;
    end
  end

  assign sum_out  = sum_q;
  assign norm_out = norm_q;

endmodule

// File: tb/tb_psum_norm.sv
// Directed, table-driven bench for psum_norm plus a reset-during-divide sequence.
module tb_psum_norm;
  import psum_norm_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [col*bw_psum-1:0] psum_in;
  logic                   psum_valid;
  logic                   ready;
  logic [bw_sum-1:0]      sum_out;
  logic                   sum_wr;
  logic                   sum_full;
  logic [bw_sum-1:0]      rsum_in;
  logic                   rsum_empty;
  logic                   rsum_rd;
  logic [col*bw-1:0]      norm_out;
  logic                   out_valid;

  always #5 clk = ~clk;

  psum_norm dut (
    .clk        (clk),
    .reset      (reset),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .ready      (ready),
    .sum_out    (sum_out),
    .sum_wr     (sum_wr),
    .sum_full   (sum_full),
    .rsum_in    (rsum_in),
    .rsum_empty (rsum_empty),
    .rsum_rd    (rsum_rd),
    .norm_out   (norm_out),
    .out_valid  (out_valid)
  );

  typedef struct packed {
    logic [col-1:0][bw_psum-1:0] p;
    logic [bw_sum-1:0]           rsum;
    logic [bw_sum-1:0]           exp_sum;
    logic [col-1:0][bw-1:0]      exp;
    int                          full_cyc;
    int                          empty_cyc;
  } vec_t;

  localparam int NVec = 8;
  vec_t vecs [NVec];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer vector vi, then follow it cycle by cycle; cycle k is k clocks after acceptance.
  task automatic run_vec(input int vi);
    vec_t v;
    int wr_k, rd_k, out_k, nwr, nrd;
    logic [bw_sum-1:0] wr_val;
    v = vecs[vi];
    wr_k = -1; rd_k = -1; out_k = -1; nwr = 0; nrd = 0; wr_val = '0;
    @(negedge clk);
    psum_in    = v.p;
    rsum_in    = v.rsum;
    psum_valid = 1'b1;
    sum_full   = (v.full_cyc > 0);
    rsum_empty = 1'b1;
    #1;
    chk($sformatf("v%0d ready_before", vi), 64'(ready), 64'd1);
    @(posedge clk);
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      psum_valid = 1'b0;
      sum_full   = (k <= v.full_cyc);
      rsum_empty = (k <= 1 + v.full_cyc + v.empty_cyc);
      #1;
      if (k == 1) chk($sformatf("v%0d ready_busy", vi), 64'(ready), 64'd0);
      if (sum_wr) begin
        nwr++;
        wr_k   = k;
        wr_val = sum_out;
      end
      if (rsum_rd) begin
        nrd++;
        rd_k = k;
      end
      if (out_valid) begin
        out_k = k;
        break;
      end
    end
    if (out_k < 0) $display("FAIL v%0d timeout: got no out_valid, expected one", vi);
    if (out_k < 0) errors++;
    chk($sformatf("v%0d sum_out", vi), 64'(wr_val), 64'(v.exp_sum));
    chk($sformatf("v%0d sum_wr_cycle", vi), 64'(wr_k), 64'(1 + v.full_cyc));
    chk($sformatf("v%0d rsum_rd_cycle", vi), 64'(rd_k), 64'(2 + v.full_cyc + v.empty_cyc));
    chk($sformatf("v%0d out_cycle", vi), 64'(out_k), 64'(227 + v.full_cyc + v.empty_cyc));
    chk($sformatf("v%0d pushes", vi), 64'(nwr), 64'd1);
    chk($sformatf("v%0d pops", vi), 64'(nrd), 64'd1);
    chk($sformatf("v%0d norm_out", vi), 64'(norm_out), 64'(v.exp));
    @(negedge clk);
    #1;
    chk($sformatf("v%0d norm_hold", vi), 64'(norm_out), 64'(v.exp));
    chk($sformatf("v%0d ready_after", vi), 64'({ready, out_valid}), 64'b10);
  endtask

  initial begin
    int nwr, nrd, nout, nbusy;
    for (int i = 0; i < NVec; i++) vecs[i] = '0;
    // 0: uniform 100s, remote 800 -> total 1600, each 100*128/1600 = 8
    for (int k = 0; k < int'(col); k++) begin
      vecs[0].p[k]   = 20'd100;
      vecs[0].exp[k] = 8'd8;
    end
    vecs[0].rsum = 24'd800; vecs[0].exp_sum = 24'd800;
    // 1: sign, total 800 -> -64, 64
    vecs[1].p[0] = -20'sd400; vecs[1].p[1] = 20'd400; vecs[1].exp_sum = 24'd800;
    vecs[1].exp[0] = -8'sd64; vecs[1].exp[1] = 8'd64;
    // 2: |psum| == total -> quotient 128 clamps to 127
    vecs[2].p[0] = 20'd500; vecs[2].exp_sum = 24'd500; vecs[2].exp[0] = 8'd127;
    // 3: all zero, total zero -> all zero, same latency
    // 4: uniform with 10 cycles full and 20 cycles empty
    vecs[4] = vecs[0]; vecs[4].full_cyc = 10; vecs[4].empty_cyc = 20;
    // 5: most negative psum alone -> -127
    vecs[5].p[0] = 20'h80000; vecs[5].exp_sum = 24'h080000; vecs[5].exp[0] = -8'sd127;
    // 6: truncating quotients, total 15: 384/15=25, 640/15=42, 896/15=59
    vecs[6].p[0] = 20'd3; vecs[6].p[1] = -20'sd5; vecs[6].p[2] = 20'd7;
    vecs[6].exp_sum = 24'd15;
    vecs[6].exp[0] = 8'd25; vecs[6].exp[1] = -8'sd42; vecs[6].exp[2] = 8'd59;
    // 7: remote-dominated total 800, element 7 -> -100*128/800 = -16
    vecs[7].p[7] = -20'sd100; vecs[7].rsum = 24'd700; vecs[7].exp_sum = 24'd100;
    vecs[7].exp[7] = -8'sd16;

    reset = 1'b0; psum_in = '0; psum_valid = 1'b0; sum_full = 1'b0;
    rsum_in = '0; rsum_empty = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({ready, sum_wr, rsum_rd, out_valid}), 64'b1000);
    chk("reset_sum_out", 64'(sum_out), 64'd0);
    chk("reset_norm_out", 64'(norm_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVec; i++) run_vec(i);

    // Reset 100 cycles after acceptance, in the middle of the divide phase.
    @(negedge clk);
    psum_in = vecs[0].p; rsum_in = vecs[0].rsum; psum_valid = 1'b1;
    sum_full = 1'b0; rsum_empty = 1'b0;
    @(posedge clk);
    nwr = 0; nrd = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      psum_valid = 1'b0;
      if (k == 100) reset = 1'b0;
      #1;
      if (sum_wr) nwr++;
      if (rsum_rd) nrd++;
    end
    chk("rst_mid_outputs", 64'({ready, sum_wr, rsum_rd, out_valid}), 64'b1000);
    chk("rst_mid_sum_out", 64'(sum_out), 64'd0);
    chk("rst_mid_norm_out", 64'(norm_out), 64'd0);
    chk("rst_mid_pushes", 64'(nwr), 64'd1);
    chk("rst_mid_pops", 64'(nrd), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    nwr = 0; nrd = 0; nout = 0; nbusy = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (sum_wr) nwr++;
      if (rsum_rd) nrd++;
      if (out_valid) nout++;
      if (!ready) nbusy++;
    end
    chk("rst_after_activity", 64'({nwr[7:0], nrd[7:0], nout[7:0], nbusy[7:0]}), 64'd0);
    run_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
